boot_loader: RTL
================

# boot_loader

Parametrised program loader and reset sequencer for the RV32I core. It accepts a stream of instruction words over a valid/ready interface and writes them into the core's instruction memory from address 0. It holds the core in reset while loading, then releases it after a programmable hold time. The block replaces hand-driven reset toggling and supports reloading, capacity checking and error reporting.

## Interface
- DataWidth, 32, instruction word width.
- Address, 8, instruction-memory address width; capacity Depth = 2^Address words.
- HoldCycles, 4, cycles the core stays in reset after the last word is written; legal range ≥1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load.
- in_valid  input  1  stream word valid.
- in_data  input  DataWidth  instruction word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  loader can accept a word.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  Address  write word address.
- imem_wdata  output  DataWidth  write data.
- core_rst  output  1  active-high reset to the core.
- done  output  1  program loaded and core running.
- error  output  1  overflow detected; sticky.
- word_count  output  Address+1  words written in the current or last load.

## Operation
- States: IDLE, LOAD, HOLD, RUN, ERROR.
- Reset values:
  - state = IDLE.
  - core_rst = 1.
  - in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - done = 0, error = 0, word_count = 0.
- IDLE: core_rst = 1. On start → LOAD; word_count cleared to 0.
- LOAD:
  - in_ready = 1; combinational from state only.
  - A beat is accepted when in_valid && in_ready.
  - Each accepted beat writes in_data to address word_count[Address-1:0], then word_count increments.
  - Beat with in_last → HOLD.
  - Beat accepted at index Depth-1 without in_last → ERROR. That word is still written; memory is full.
  - A beat with in_last at index Depth-1 is legal → HOLD.
  - start is ignored.
- HOLD:
  - in_ready = 0, core_rst = 1.
  - Hold counter loads HoldCycles on entry and decrements every cycle.
  - On reaching 1 → RUN.
  - start is ignored.
- RUN: core_rst = 0, done = 1, word_count holds. On start → LOAD; core_rst reasserts and done clears at the same edge; word_count cleared.
- ERROR:
  - error = 1, core_rst = 1, in_ready = 0, done = 0.
  - On start → LOAD; error clears and word_count clears.
- word_count arithmetic is Address+1 bits wide and never wraps, because the maximum value is Depth.
- Async rst in any state returns all outputs to their reset values immediately. Partially written memory is not scrubbed.

## Timing
- Write latency is 1 cycle. For a beat accepted at edge N, imem_we/imem_addr/imem_wdata are registered and valid in the cycle after edge N. imem_we is high for exactly one cycle per beat.
- Back-to-back beats give continuous imem_we, one write per cycle.
- The last beat is accepted at edge N:
  - state = HOLD from edge N.
  - The last write is visible during the first HOLD cycle.
  - core_rst falls and done rises at edge N+HoldCycles.
- core_rst, done and error are registered outputs; no combinational path from inputs.
- start arriving on the same edge as the in_last beat (in LOAD): start is ignored and the last beat is processed normally.
- The ERROR transition happens at the edge accepting the overflowing beat. error is high from the next cycle.
- in_valid outside LOAD has no effect. Upstream must hold in_data stable until the beat is accepted.

## Test plan
- Basic load: reset, start, 3 beats 0x00500093, 0x00300113, 0x002081B3 (last on third, back-to-back).
  - Required: writes to addr 0/1/2 with those values on consecutive cycles.
  - word_count = 3.
  - core_rst falls exactly 4 cycles after the last-beat edge; done = 1.
- Backpressure and gaps: in_valid toggled 1,0,1,0,1 with last on the third beat.
  - Required: only 3 writes, to addr 0..2.
  - imem_we is never high in gap cycles.
- Exact capacity with Address = 2 (Depth 4): 4 beats, last on the 4th.
  - Required: RUN, error = 0, word_count = 4.
  - Same setup without last on the 4th: ERROR, error = 1, core_rst stays 1, 4 writes made.
- Reload from RUN: after the basic load, pulse start.
  - Required: core_rst = 1 and done = 0 at the next edge; word_count = 0.
  - A new 2-word program writes addr 0/1, then returns to RUN.
- Reset mid-load: assert rst after 2 of 5 beats.
  - Required: core_rst = 1, in_ready = 0, imem_we = 0, word_count = 0 without waiting for a clock edge; state IDLE.
  - start is needed before any further write.
- Error recovery: from ERROR, pulse start and load 1 word with last.
  - Required: error clears, write to addr 0, RUN after HoldCycles.

Source files
------------

// File: rtl/boot_loader.sv
// Program loader and reset sequencer: streams instruction words into imem from address 0,
// holds the core in reset during the load and releases it a fixed number of cycles later.
module boot_loader #(
    parameter int DataWidth  = 32,
    parameter int Address    = 8,
    parameter int HoldCycles = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [Address-1:0]   imem_addr,
    output logic [DataWidth-1:0] imem_wdata,
    output logic                 core_rst,
    output logic                 done,
    output logic                 error,
    output logic [Address:0]     word_count
);

    localparam int Depth = 1 << Address;
    localparam int HoldW = $clog2(HoldCycles + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        ERROR
    } state_t;

    state_t                 state_reg, state_next;
    logic [HoldW-1:0]       hold_reg, hold_next;
    logic [Address:0]       count_reg, count_next;
    logic                   we_reg, we_next;
    logic [Address-1:0]     addr_reg, addr_next;
    logic [DataWidth-1:0]   wdata_reg, wdata_next;
    logic                   core_rst_reg, core_rst_next;
    logic                   done_reg, done_next;
    logic                   error_reg, error_next;
    logic                   beat;

    assign in_ready = (state_reg == LOAD);
    assign beat     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            count_reg    <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            count_reg    <= count_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            core_rst_reg <= core_rst_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        case (state_reg)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    we_next    = 1'b1;
                    addr_next  = count_reg[Address-1:0];
                    wdata_next = in_data;
                    count_next = count_reg + (Address+1)'(1);
                    if (in_last) begin
                        state_next = HOLD;
                        hold_next  = HoldW'(HoldCycles);
                    end else if (count_reg == (Address+1)'(Depth - 1)) begin
                        // Memory is now full and the program has not ended.
                        state_next = ERROR;
                    end
                end
            end
            HOLD: begin
                if (hold_reg == HoldW'(1)) begin
                    state_next = RUN;
                end else begin
                    hold_next = hold_reg - HoldW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state.
        core_rst_next = (state_next != RUN);
        done_next     = (state_next == RUN);
        error_next    = (state_next == ERROR);
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign word_count = count_reg;

endmodule
